// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN output-stationary systolic array: stores A and B, then streams
// A rows west and B columns north with a diagonal skew after a one-cycle array clear.
module systolic_feeder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [W-1:0]         wr_data,
    input  logic                 start,
    output logic [N*W-1:0]       a_edge,
    output logic [N*W-1:0]       b_edge,
    output logic                 array_rst,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned CntW  = $clog2(3 * N);
    localparam int unsigned LastT = 3 * N - 3;

    typedef enum logic [1:0] {StIdle, StClear, StStream, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      a_mem [N][N];
    logic [W-1:0]      b_mem [N][N];

    logic [N*W-1:0]    a_edge_d, b_edge_d;
    logic              array_rst_d, busy_d, done_d;
    logic [CntW-1:0]   k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: if (start) state_d = StClear;
            StClear: begin
                state_d = StStream;
                cnt_d   = '0;
            end
            StStream: begin
                if (cnt_q == CntW'(LastT)) state_d = StDone;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand storage; the write port is only live while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_mem[IdxW'(r)][IdxW'(c)] <= '0;
                    b_mem[IdxW'(r)][IdxW'(c)] <= '0;
                end
            end
        end else if (wr_en && state_q == StIdle) begin
            if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
            else        a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Row/column i carries element (t-i) of its line while 0 <= t-i < N, zero otherwise.
    always_comb begin
        a_edge_d    = '0;
        b_edge_d    = '0;
        k           = '0;
        array_rst_d = (state_q == StClear);
        busy_d      = (state_q != StIdle);
        done_d      = (state_q == StDone);
        if (state_q == StStream) begin
            for (int unsigned i = 0; i < N; i++) begin
                k = cnt_q - CntW'(i);
                if (cnt_q >= CntW'(i) && k < CntW'(N)) begin
                    a_edge_d[i*W +: W] = a_mem[IdxW'(i)][k[IdxW-1:0]];
                    b_edge_d[i*W +: W] = b_mem[k[IdxW-1:0]][IdxW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_edge    <= '0;
            b_edge    <= '0;
            array_rst <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            a_edge    <= a_edge_d;
            b_edge    <= b_edge_d;
            array_rst <= array_rst_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: drives a behavioural cell array from the feeder
// edges and checks timing, skew, guards and final products against hand-computed values.
module tb_systolic_feeder;

    localparam int N = 4;
    localparam int W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [$clog2(N)-1:0] wr_row = '0;
    logic [$clog2(N)-1:0] wr_col = '0;
    logic [W-1:0]         wr_data = '0;
    logic                 start = 1'b0;
    logic [N*W-1:0]       a_edge, b_edge;
    logic                 array_rst, busy, done;

    int vectors = 0;
    int miscompares = 0;

    int           acc [N][N];
    logic [W-1:0] ar  [N][N];
    logic [W-1:0] br  [N][N];
    logic [W-1:0] ain, bin;
    int           exp_c [N][N];

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .array_rst (array_rst),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural cell array: forward operands one cycle later, accumulate on the same edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain = a_edge[i*W +: W];
                else        ain = ar[i][j-1];
                if (i == 0) bin = b_edge[j*W +: W];
                else        bin = br[i-1][j];
                if (array_rst) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
                    ar[i][j]  <= ain;
                    br[i][j]  <= bin;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 8'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps from cycle c0 after the start edge until done; done must land at +3N.
    task automatic wait_done(input string tag, input int c0);
        int  c = c0;
        logic found = 1'b0;
        while (!found && c < 60) begin
            step();
            c++;
            found = done;
        end
        chk(tag, 64'(c), 64'(3 * N));
    endtask

    task automatic check_cells(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_cell%0d%0d", tag, i, j), 64'(acc[i][j]), 64'(exp_c[i][j]));
    endtask

    task automatic run_check(input string tag);
        kick();
        step();
        chk({tag, "_array_rst"}, 64'(array_rst), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done({tag, "_done_lat"}, 1);
        check_cells(tag);
        step();
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
        chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    task automatic set_exp_const(input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_c[i][j] = v;
    endtask

    task automatic set_exp_b();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_c[i][j] = 4 * i + j + 1;
    endtask

    task automatic load_identity_a();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr(1'b0, r, c, (r == c) ? 1 : 0);
    endtask

    initial begin
        int ev3 [N];
        int ev6 [N];
        int cnt;
        ev3 = '{3, 18, 33, 48};
        ev6 = '{0, 0, 0, 51};

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_array_rst", 64'(array_rst), 64'd0);
        chk("rst_a_edge", 64'(a_edge), 64'd0);
        chk("rst_b_edge", 64'(b_edge), 64'd0);
        set_exp_const(0);
        run_check("zero");

        // Identity product
        load_identity_a();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr(1'b1, r, c, 4 * r + c + 1);
        set_exp_b();
        run_check("ident");

        // Skew
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr(1'b0, r, c, 16 * r + c);
        kick();
        repeat (5) step();
        for (int i = 0; i < N; i++)
            chk($sformatf("skew_t3_s%0d", i), 64'(a_edge[i*W +: W]), 64'(ev3[i]));
        repeat (3) step();
        for (int i = 0; i < N; i++)
            chk($sformatf("skew_t6_s%0d", i), 64'(a_edge[i*W +: W]), 64'(ev6[i]));
        for (int t = 7; t <= 9; t++) begin
            step();
            chk($sformatf("skew_t%0d_a", t), 64'(a_edge), 64'd0);
            chk($sformatf("skew_t%0d_b", t), 64'(b_edge), 64'd0);
        end
        step();
        chk("skew_done", 64'(done), 64'd1);
        step();

        // Busy guards: start and write at t=2 must be ignored
        load_identity_a();
        kick();
        repeat (4) step();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = 8'd99;
        step();
        start   = 1'b0;
        wr_en   = 1'b0;
        wait_done("guard_done_lat", 5);
        check_cells("guard");
        cnt = 0;
        repeat (14) begin
            step();
            if (done || busy || array_rst) cnt++;
        end
        chk("guard_no_requeue", 64'(cnt), 64'd0);
        run_check("guard_rerun");

        // Reset mid-stream
        kick();
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_a_edge", 64'(a_edge), 64'd0);
        chk("mid_rst_b_edge", 64'(b_edge), 64'd0);
        chk("mid_rst_array_rst", 64'(array_rst), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        cnt = 0;
        repeat (20) begin
            step();
            if (done) cnt++;
        end
        chk("mid_rst_no_done", 64'(cnt), 64'd0);
        set_exp_const(0);
        run_check("mid_rst_zeroed");
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 2);
                wr(1'b1, r, c, 3);
            end
        set_exp_const(24);
        run_check("mid_rst_rerun");

        // Back-to-back with start held high
        start = 1'b1;
        step();
        step();
        chk("b2b_rst1", 64'(array_rst), 64'd1);
        wait_done("b2b_done1", 1);
        check_cells("b2b_run1");
        step();
        chk("b2b_gap_busy", 64'(busy), 64'd0);
        chk("b2b_gap_rst", 64'(array_rst), 64'd0);
        start = 1'b0;
        step();
        chk("b2b_rst2", 64'(array_rst), 64'd1);
        wait_done("b2b_done2", 1);
        check_cells("b2b_run2");
        step();
        step();
        chk("b2b_end_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

- Operand feeder for the N×N output-stationary systolic multiplier built from `Cell` tiles.
- Holds two N×N 8-bit matrices, A and B, loaded through a simple write port.
- On `start`, it clears the array and streams A rows into the west edge and B columns into the north edge, skewed diagonally so every cell (i,j) accumulates Σk A[i][k]·B[k][j].
- It is the producing end of the `a_in`/`b_in` stream that each `Cell` consumes and forwards.

## Interface
- `N`, 4, array dimension (rows = cols = N, N ≥ 2)
- `W`, 8, operand width in bits
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write strobe; honoured only in IDLE
- `wr_sel`  in  1  0 = write A, 1 = write B
- `wr_row`  in  clog2(N)  row index
- `wr_col`  in  clog2(N)  column index
- `wr_data`  in  W  element value
- `start`  in  1  single-cycle run request; honoured only in IDLE
- `a_edge`  out  N·W  west-edge operands; slice i (bits i·W +: W) drives `a_in` of row i, column 0
- `b_edge`  out  N·W  north-edge operands; slice j drives `b_in` of row 0, column j
- `array_rst`  out  1  clear pulse to all cells' `rst`
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse: array results are final

## Operation
- Storage: two N×N×W register arrays, A and B, cleared to 0 by `rst`.
  - A write sets `A[wr_row][wr_col]` or `B[wr_row][wr_col]` at the clock edge.
  - Writes in any state other than IDLE are dropped.
  - If `wr_en` and `start` are both high in IDLE, the write lands first and the run uses the new value.
- FSM states: IDLE → CLEAR → STREAM → DONE → IDLE.
  - IDLE: all outputs 0. `start` = 1 moves to CLEAR.
  - CLEAR: one cycle. `array_rst` = 1, edges 0.
  - STREAM: counter t runs 0 … 3N−3, for 3N−2 cycles.
    - Row slice i = A[i][t−i] when 0 ≤ t−i < N, else 0.
    - Column slice j = B[t−j][j] when 0 ≤ t−j < N, else 0.
    - Cycles with t > 2N−2 carry only zeros. They drain the skew, so the last pair A[N−1][N−1]/B[N−1][N−1] reaches cell (N−1,N−1) at t = 3N−3.
    - Leave STREAM when t = 3N−3.
  - DONE: one cycle with `done` = 1, then IDLE.
- `start` outside IDLE is ignored and is not queued.
- Data widths: edges carry raw W-bit elements. Accumulation width and overflow are owned by `Cell`.
- Cell contract (decided): each cell registers `a_out`/`b_out` one cycle after its inputs and accumulates `a_in·b_in` on the same edge.

## Timing
- All outputs are registered. Every output, the counter and both matrices reset to 0, and the FSM resets to IDLE.
- With `start` sampled high at edge k:
  - edge k+1: `array_rst` = 1, `busy` = 1.
  - edges k+2 … k+3N−1: STREAM, t = 0 … 3N−3. For example `a_edge` slice 0 = A[0][0] during k+2.
  - edge k+3N: `done` = 1.
  - edge k+3N+1: IDLE, `busy` = 0, and a new `start` is accepted in this same cycle.
- Start-to-done latency is 3N cycles, 12 for N = 4.
- `rst` asserted mid-run:
  - Next edge: IDLE, all outputs 0, matrices zeroed, no `done`.
  - The array is not cleared by this block; the next run's CLEAR cycle handles it.
- Back-to-back: `start` held high continuously yields one run every 3N+1 cycles.

## Test plan
- Reset: hold `rst` 2 cycles → `busy`, `done`, `array_rst`, `a_edge`, `b_edge` all 0. Run with no writes → 16 zero cells, `done` at start+12.
- Identity product, N=4: load A = I, B[r][c] = 4r+c+1, then `start` → `array_rst` at +1, `done` at +12, cell (i,j) result = 4i+j+1.
- Skew check with A[r][c] = 16r+c, N=4:
  - at t=3, `a_edge` slices 0..3 = {3, 18, 33, 48};
  - at t=6, slices = {0, 0, 0, 51};
  - t=7…9 all zero.
- Busy guards: pulse `start` and write A[0][0]=99 at t=2 → stream and results unchanged, single `done`, A[0][0] unchanged afterwards.
- Reset mid-stream: assert `rst` at t=4 → all outputs 0 next cycle, no `done`. Reload, rerun → correct product (A all 2, B all 3 → every result 24).
- Back-to-back: `start` held high over two runs → second `array_rst` one cycle after the first `done`, and both products are correct.
